mnist_batch_runner: RTL and testbench

Parametrised multi-channel front end for `mnist_classifier`. It holds NUM_CH binarised image buffers that are filled over a valid/ready pixel stream, and it waits a fixed classifier latency per channel. Finished digits are returned through a round-robin arbitrated valid/ready result port. It replaces the fixed four-channel runner and adds flow control, frame framing, per-channel status and a length-error flag.

---
 rtl/mnist_pkg.sv | 35 +++
 rtl/mnist_batch_runner_if.sv | 27 ++
 rtl/mnist_channel.sv | 73 +++++++
 rtl/mnist_classifier.sv | 11 +
 rtl/mnist_batch_runner.sv | 106 ++++++++++
 tb/tb_mnist_batch_runner.sv | 288 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mnist_pkg.sv
// Shared types and the reference classifier function for the MNIST batch runner.
package mnist_pkg;

  localparam int MNIST_PIXELS = 784;
  localparam int MNIST_ROW    = 28;
  localparam int ADDR_W       = 10;

  typedef logic [3:0]              digit_t;
  typedef logic [0:MNIST_PIXELS-1] image_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } ch_state_e;

  // Digit = (set pixels in the whole image + set pixels in the top row) mod 10.
  function automatic digit_t classify(input image_t img);
    logic [ADDR_W-1:0] tot;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] sum;
    tot = '0;
    row = '0;
    for (int i = 0; i < MNIST_PIXELS; i++) begin
      if (img[ADDR_W'(i)]) begin
        tot = tot + 1'b1;
        if (i < MNIST_ROW) row = row + 1'b1;
      end
    end
    sum = tot + row;
    return digit_t'(sum % ADDR_W'(10));
  endfunction

endpackage

// File: rtl/mnist_batch_runner_if.sv
// Pixel-in / result-out valid-ready bus of the MNIST batch runner.
interface mnist_batch_runner_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [7:0]      in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [3:0]      out_digit;

  modport master (
    output in_valid, in_ch, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_ch, out_digit
  );

  modport slave (
    input  in_valid, in_ch, in_data, in_last, out_ready,
    output in_ready, out_valid, out_ch, out_digit
  );

endinterface

// File: rtl/mnist_channel.sv
// One classifier channel: image buffer, load/wait/done FSM and classifier instance.
module mnist_channel
  import mnist_pkg::*;
#(
  parameter int CLS_LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      wr_en,
  input  logic      pix_bit,
  input  logic      grant,
  output ch_state_e state,
  output logic      last_beat,
  output digit_t    digit
);

  localparam int                CNT_W     = $clog2(CLS_LATENCY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MNIST_PIXELS - 1);

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  image_t            image;
  digit_t            cls_digit;

  assign last_beat = (state == LOAD) && (addr == LAST_ADDR);

  // NOTE: the image buffer has no reset; every frame overwrites all 784 bits before use.
  always_ff @(posedge clk) begin
    if (wr_en) image[addr] <= pix_bit;
  end

  mnist_classifier u_cls (
    .image (image),
    .digit (cls_digit)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      digit <= '0;
    end else begin
      case (state)
        IDLE: if (wr_en) begin
          addr  <= ADDR_W'(1);
          state <= LOAD;
        end
        LOAD: if (wr_en) begin
          if (last_beat) begin
            addr  <= '0;
            cnt   <= CNT_W'(CLS_LATENCY);
            state <= WAIT;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            digit <= cls_digit;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (grant) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mnist_classifier.sv
// Combinational digit classifier; the channel's latency counter covers its settle time.
module mnist_classifier
  import mnist_pkg::*;
(
  input  image_t image,
  output digit_t digit
);

  assign digit = classify(image);

endmodule

// File: rtl/mnist_batch_runner.sv
// NUM_CH-channel MNIST front end with round-robin result port and sticky length error.
// Optional macro MNIST_RUNNER_THRESH_EN: binarise with in_data >= PIX_THRESH instead of in_data[7].
module mnist_batch_runner
  import mnist_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLS_LATENCY = 2,
  parameter int PIX_THRESH  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  mnist_batch_runner_if.slave   bus,
  output logic [NUM_CH-1:0]     busy,
  output logic                  err_len
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_state_e        ch_state [NUM_CH];
  digit_t           ch_digit [NUM_CH];
  logic [NUM_CH-1:0] ch_last;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_open;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] ch_grant;

  logic            pix_bit;
  logic            accept;
  logic            last_hit;
  logic            slot_load;
  logic            any_done;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W-1:0] rr_ptr;

`ifdef MNIST_RUNNER_THRESH_EN
  assign pix_bit = ({24'd0, bus.in_data} >= PIX_THRESH);
`else
  assign pix_bit = bus.in_data[7];
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_hit[c]   = (bus.in_ch == CH_W'(c));
    assign ch_open[c]  = (ch_state[c] == IDLE) || (ch_state[c] == LOAD);
    assign ch_done[c]  = (ch_state[c] == DONE);
    assign busy[c]     = (ch_state[c] != IDLE);
    assign ch_wr[c]    = bus.in_valid && ch_hit[c] && ch_open[c];
    assign ch_grant[c] = slot_load && any_done && (gnt_idx == CH_W'(c));

    mnist_channel #(
      .CLS_LATENCY (CLS_LATENCY)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ch_wr[c]),
      .pix_bit   (pix_bit),
      .grant     (ch_grant[c]),
      .state     (ch_state[c]),
      .last_beat (ch_last[c]),
      .digit     (ch_digit[c])
    );
  end

  // An out-of-range in_ch matches no channel, so in_ready stays low.
  assign bus.in_ready = |(ch_hit & ch_open);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_hit     = |(ch_hit & ch_last);
  assign slot_load    = !bus.out_valid || bus.out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    any_done = 1'b0;
    gnt_idx  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_done && ch_done[CH_W'(idx)]) begin
        any_done = 1'b1;
        gnt_idx  = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_digit <= '0;
      rr_ptr        <= '0;
      err_len       <= 1'b0;
    end else begin
      if (slot_load) begin
        bus.out_valid <= any_done;
        if (any_done) begin
          bus.out_ch    <= gnt_idx;
          bus.out_digit <= ch_digit[gnt_idx];
          rr_ptr        <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      if (accept && (last_hit != bus.in_last)) err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mnist_batch_runner.sv
// Scoreboard bench for mnist_batch_runner: frames queue expected digits, result handshakes pop them.
module tb_mnist_batch_runner;
  import mnist_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int CLS_LATENCY = 2;
  localparam int PIX_THRESH  = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] busy;
  logic              err_len;

  mnist_batch_runner_if #(.NUM_CH(NUM_CH)) bus ();

  mnist_batch_runner #(
    .NUM_CH      (NUM_CH),
    .CLS_LATENCY (CLS_LATENCY),
    .PIX_THRESH  (PIX_THRESH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int digit;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   t_acc = 0;

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int i);
    case (pat)
      0:       return (i < 100) ? 8'd200 : 8'd0;
      1:       return (i % 3 == 0) ? 8'd255 : 8'd10;
      2:       return 8'((i * 7) % 256);
      3:       return 8'd120;
      4:       return (i >= 700) ? 8'd130 : 8'd127;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic model_bit(input logic [7:0] d);
`ifdef MNIST_RUNNER_THRESH_EN
    return int'(d) >= PIX_THRESH;
`else
    return d >= 8'd128;
`endif
  endfunction

  function automatic int model_digit(input int pat);
    int tot = 0;
    int row = 0;
    for (int i = 0; i < 784; i++) begin
      if (model_bit(pix(pat, i))) begin
        tot++;
        if (i < 28) row++;
      end
    end
    return (tot + row) % 10;
  endfunction

  task automatic send_beat(input int ch, input logic [7:0] d, input logic last);
    int budget = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'(ch);
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    while (!bus.in_ready && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      report();
    end
    @(posedge clk);
    #1;
    t_acc = cyc;
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int ch, input int pat, input int start,
                            input int extra_last, input bit last_ok);
    for (int i = start; i < 784; i++)
      send_beat(ch, pix(pat, i), (i == 783 && last_ok) || i == extra_last);
    sb.push_back('{ch: ch, digit: model_digit(pat)});
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Result monitor: a handshake seen mid-cycle completes on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_ch", 32'(bus.out_ch), e.ch);
          check("out_digit", 32'(bus.out_digit), e.digit);
        end
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    int t_last;
    int hs0;
    int found;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_out_digit", 32'(bus.out_digit), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single frame on channel 0 with latency measurement.
    send_frame(0, 0, 0, -1, 1'b1);
    t_last = t_acc;
    idle_in();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) found = 1;
    end
    check("out_valid_seen", 32'(found), 32'd1);
    check("latency", 32'(cyc - t_last), 32'(CLS_LATENCY + 2));
    check("busy0_idle", 32'(busy[0]), 32'd0);
    @(negedge clk);
    #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("err_len_clean", 32'(err_len), 32'd0);

    // Interleaved frames on channels 1 and 3 with the result port stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 784; i++) begin
      send_beat(1, pix(1, i), i == 783);
      send_beat(3, pix(2, i), i == 783);
    end
    sb.push_back('{ch: 1, digit: model_digit(1)});
    sb.push_back('{ch: 3, digit: model_digit(2)});
    idle_in();
    repeat (6) @(negedge clk);
    #1;
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    check("stall_busy3", 32'(busy[3]), 32'd1);
    check("stall_busy1", 32'(busy[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("hold_ch", 32'(bus.out_ch), 32'd1);
      check("hold_digit", 32'(bus.out_digit), 32'(model_digit(1)));
    end
    hs0 = hs_cyc.size();
    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("b2b_count", 32'(hs_cyc.size() - hs0), 32'd2);
    if (hs_cyc.size() - hs0 == 2)
      check("b2b_gap", 32'(hs_cyc[hs0 + 1] - hs_cyc[hs0]), 32'd1);

    // Channel 2 is closed to beats during WAIT and DONE, reopens after its grant.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_frame(0, 4, 0, -1, 1'b1);
    send_frame(2, 2, 0, -1, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ch    = 2'd2;
    bus.in_data  = pix(1, 0);
    bus.in_last  = 1'b0;
    for (int k = 0; k < CLS_LATENCY + 4; k++) begin
      #1;
      check("ch2_closed", 32'(bus.in_ready), 32'd0);
      check("ch2_busy", 32'(busy[2]), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("ch2_grant_cycle", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1;
    check("ch2_reopen", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_frame(2, 1, 1, -1, 1'b1);
    idle_in();
    drain("drain_ch2");

    // Early in_last on beat 500 sets the sticky error; the frame still completes.
    check("err_before_early", 32'(err_len), 32'd0);
    send_frame(1, 0, 0, 499, 1'b1);
    idle_in();
    check("err_early", 32'(err_len), 32'd1);
    drain("drain_early");
    check("err_sticky", 32'(err_len), 32'd1);

    // Reset in the middle of a channel 0 frame.
    for (int i = 0; i < 300; i++) send_beat(0, pix(1, i), 1'b0);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(0, 2, 0, -1, 1'b1);
    idle_in();
    drain("drain_after_rst");

    // Threshold behaviour for mid-grey pixels.
    send_frame(3, 3, 0, -1, 1'b1);
    idle_in();
    drain("drain_thresh");
    check("err_after_thresh", 32'(err_len), 32'd0);

    // Missing in_last on the 784th beat.
    send_frame(2, 0, 0, -1, 1'b0);
    idle_in();
    check("err_missing_last", 32'(err_len), 32'd1);
    drain("drain_final");

    repeat (3) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("final_out_valid", 32'(bus.out_valid), 32'd0);
    report();
  end

endmodule
